dpll_branch_sched: RTL and testbench

- Sequencing controller for the DPLL search in the hardware SAT solver.
- Drives the formula evaluator through a request/ack handshake and keeps the decision stack (literal, polarity, flipped flag) internally.
- Issues single-cycle commands to the formula stack (push/restore/pop) and to the assignment datapath.
- Reports SAT/UNSAT, a protocol error, and a decision count.

---
 rtl/dpll_branch_sched.sv | 212 +++++++++++++++++++++
 tb/tb_dpll_branch_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_branch_sched.sv
// DPLL search sequencer: evaluator handshake, internal decision stack, formula-stack commands.
// Optional macro DPLL_EVAL_TIMEOUT_EN adds an EVAL watchdog of EVAL_TIMEOUT cycles.
module dpll_branch_sched #(
    parameter int unsigned NUM_LIT      = 5,
    parameter int unsigned STACK_DEPTH  = 5,
    parameter int unsigned LW           = $clog2(NUM_LIT + 1),
    parameter int unsigned DW           = $clog2(STACK_DEPTH + 1),
    parameter int unsigned EVAL_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          eval_req,
    input  logic          eval_ack,
    input  logic [1:0]    eval_status,
    input  logic [LW-1:0] eval_lit_num,
    input  logic          eval_lit_val,
    output logic          snap_push,
    output logic          snap_restore,
    output logic          snap_pop,
    output logic          assign_valid,
    output logic [LW-1:0] assign_num,
    output logic          assign_val,
    output logic [DW-1:0] depth,
    output logic          done,
    output logic          sat,
    output logic          err,
    output logic [15:0]   dec_count
);

    localparam logic [1:0] EvUndecided = 2'b00;
    localparam logic [1:0] EvConflict  = 2'b01;
    localparam logic [1:0] EvSat       = 2'b10;
    localparam logic [1:0] EvUnit      = 2'b11;

    if (STACK_DEPTH < NUM_LIT || EVAL_TIMEOUT == 0) begin : g_param_check
        $error("dpll_branch_sched: need STACK_DEPTH >= NUM_LIT and EVAL_TIMEOUT > 0");
    end

    typedef enum logic [2:0] {
        StIdle,
        StEval,
        StPush,
        StAssign,
        StBtCheck,
        StRestore,
        StPop,
        StFinish
    } state_t;

    state_t                 state_q;
    logic [LW-1:0]          stk_num_q [STACK_DEPTH];
    logic [STACK_DEPTH-1:0] stk_val_q;
    logic [STACK_DEPTH-1:0] stk_flip_q;
    logic [DW-1:0]          top_idx;

    // Top-of-stack entry sits one below the current decision level.
    assign top_idx = depth - 1'b1;

`ifdef DPLL_EVAL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(EVAL_TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;
    assign tmo_hit = (tmo_q == TW'(EVAL_TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            eval_req     <= 1'b0;
            snap_push    <= 1'b0;
            snap_restore <= 1'b0;
            snap_pop     <= 1'b0;
            assign_valid <= 1'b0;
            assign_num   <= '0;
            assign_val   <= 1'b0;
            depth        <= '0;
            done         <= 1'b0;
            sat          <= 1'b0;
            err          <= 1'b0;
            dec_count    <= '0;
            stk_num_q    <= '{default: '0};
            stk_val_q    <= '0;
            stk_flip_q   <= '0;
`ifdef DPLL_EVAL_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            snap_push    <= 1'b0;
            snap_restore <= 1'b0;
            snap_pop     <= 1'b0;
            assign_valid <= 1'b0;
            assign_num   <= '0;
            assign_val   <= 1'b0;
            done         <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sat       <= 1'b0;
                        err       <= 1'b0;
                        dec_count <= '0;
                        depth     <= '0;
                        eval_req  <= 1'b1;
                        state_q   <= StEval;
`ifdef DPLL_EVAL_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end

                StEval: begin
                    if (eval_ack) begin
                        eval_req <= 1'b0;
                        unique case (eval_status)
                            EvSat: begin
                                sat     <= 1'b1;
                                done    <= 1'b1;
                                state_q <= StFinish;
                            end
                            EvUnit: begin
                                assign_valid <= 1'b1;
                                assign_num   <= eval_lit_num;
                                assign_val   <= eval_lit_val;
                                state_q      <= StAssign;
                            end
                            EvUndecided: begin
                                if (eval_lit_num == '0 || depth == DW'(STACK_DEPTH)) begin
                                    err     <= 1'b1;
                                    sat     <= 1'b0;
                                    done    <= 1'b1;
                                    state_q <= StFinish;
                                end else begin
                                    stk_num_q[depth]  <= eval_lit_num;
                                    stk_val_q[depth]  <= 1'b1;
                                    stk_flip_q[depth] <= 1'b0;
                                    snap_push         <= 1'b1;
                                    depth             <= depth + 1'b1;
                                    if (dec_count != 16'hFFFF) begin
                                        dec_count <= dec_count + 16'd1;
                                    end
                                    state_q <= StPush;
                                end
                            end
                            EvConflict: state_q <= StBtCheck;
                            default:    state_q <= StBtCheck;
                        endcase
                    end
`ifdef DPLL_EVAL_TIMEOUT_EN
                    else if (tmo_hit) begin
                        eval_req <= 1'b0;
                        err      <= 1'b1;
                        sat      <= 1'b0;
                        done     <= 1'b1;
                        state_q  <= StFinish;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end

                StPush: begin
                    assign_valid <= 1'b1;
                    assign_num   <= stk_num_q[top_idx];
                    assign_val   <= stk_val_q[top_idx];
                    state_q      <= StAssign;
                end

                StAssign: begin
                    eval_req <= 1'b1;
                    state_q  <= StEval;
`ifdef DPLL_EVAL_TIMEOUT_EN
                    tmo_q    <= '0;
`endif
                end

                StBtCheck: begin
                    if (depth == '0) begin
                        sat     <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StFinish;
                    end else if (!stk_flip_q[top_idx]) begin
                        // Second branch of this decision: same literal, opposite polarity.
                        stk_flip_q[top_idx] <= 1'b1;
                        stk_val_q[top_idx]  <= 1'b0;
                        snap_restore        <= 1'b1;
                        state_q             <= StRestore;
                    end else begin
                        stk_num_q[top_idx]  <= '0;
                        stk_val_q[top_idx]  <= 1'b0;
                        stk_flip_q[top_idx] <= 1'b0;
                        snap_pop            <= 1'b1;
                        depth               <= depth - 1'b1;
                        state_q             <= StPop;
                    end
                end

                StRestore: begin
                    assign_valid <= 1'b1;
                    assign_num   <= stk_num_q[top_idx];
                    assign_val   <= stk_val_q[top_idx];
                    state_q      <= StAssign;
                end

                StPop:    state_q <= StBtCheck;
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dpll_branch_sched.sv
// Testbench for dpll_branch_sched: scripted and random evaluator responses scored
// against a queue-based DPLL reference model.
module tb_dpll_branch_sched;

    localparam int NUM_LIT = 5;
    localparam int SD      = 5;
    localparam int LW      = 3;
    localparam int DW      = 3;

    localparam int KPush    = 0;
    localparam int KRestore = 1;
    localparam int KPop     = 2;
    localparam int KAssign  = 3;
    localparam int KDone    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          eval_req;
    logic          eval_ack = 1'b0;
    logic [1:0]    eval_status = 2'b00;
    logic [LW-1:0] eval_lit_num = '0;
    logic          eval_lit_val = 1'b0;
    logic          snap_push;
    logic          snap_restore;
    logic          snap_pop;
    logic          assign_valid;
    logic [LW-1:0] assign_num;
    logic          assign_val;
    logic [DW-1:0] depth;
    logic          done;
    logic          sat;
    logic          err;
    logic [15:0]   dec_count;

    dpll_branch_sched #(
        .NUM_LIT     (NUM_LIT),
        .STACK_DEPTH (SD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .eval_req     (eval_req),
        .eval_ack     (eval_ack),
        .eval_status  (eval_status),
        .eval_lit_num (eval_lit_num),
        .eval_lit_val (eval_lit_val),
        .snap_push    (snap_push),
        .snap_restore (snap_restore),
        .snap_pop     (snap_pop),
        .assign_valid (assign_valid),
        .assign_num   (assign_num),
        .assign_val   (assign_val),
        .depth        (depth),
        .done         (done),
        .sat          (sat),
        .err          (err),
        .dec_count    (dec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int num;
        int val;
        int dep;
        int sat;
        int err;
        int dec;
    } exp_t;

    typedef struct {
        int num;
        bit flipped;
    } dec_t;

    typedef struct {
        logic [1:0] st;
        int         lit;
        bit         val;
    } rsp_t;

    exp_t exp_q[$];
    dec_t m_stk[$];
    rsp_t script[$];
    int   m_dec;
    int   m_sat;
    int   m_err;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stray_en = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void push_exp(input int kind, input int num, input int val,
                                     input int dep, input int s, input int e, input int dc);
        exp_t x;
        x.kind = kind; x.num = num; x.val = val; x.dep = dep;
        x.sat = s; x.err = e; x.dec = dc;
        exp_q.push_back(x);
    endfunction

    function automatic void add(input logic [1:0] st, input int lit, input bit val);
        rsp_t r;
        r.st = st; r.lit = lit; r.val = val;
        script.push_back(r);
    endfunction

    function automatic rsp_t rand_rsp();
        rsp_t r;
        int   p;
        p = int'($urandom_range(0, 99));
        r.val = 1'b0;
        r.lit = 0;
        if (p < 3) begin
            r.st = 2'b00;
        end else if (p < 40) begin
            r.st  = 2'b00;
            r.lit = int'($urandom_range(1, NUM_LIT));
        end else if (p < 70) begin
            r.st = 2'b01;
        end else if (p < 90) begin
            r.st  = 2'b11;
            r.lit = int'($urandom_range(1, NUM_LIT));
            r.val = 1'($urandom);
        end else begin
            r.st = 2'b10;
        end
        return r;
    endfunction

    // Reference DPLL step: expected command sequence, cycles until next eval_req/done.
    task automatic model_ack(input logic [1:0] st, input int lit, input bit val,
                             output int lat, output bit fin);
        dec_t t;
        bit   going;
        lat = 1;
        fin = 1'b0;
        case (st)
            2'b10: begin
                m_sat = 1; m_err = 0;
                push_exp(KDone, 0, 0, m_stk.size(), 1, 0, m_dec);
                fin = 1'b1;
            end
            2'b11: begin
                push_exp(KAssign, lit, int'(val), m_stk.size(), 0, 0, 0);
                lat = 2;
            end
            2'b00: begin
                if (lit == 0 || m_stk.size() == SD) begin
                    m_sat = 0; m_err = 1;
                    push_exp(KDone, 0, 0, m_stk.size(), 0, 1, m_dec);
                    fin = 1'b1;
                end else begin
                    t.num = lit; t.flipped = 1'b0;
                    m_stk.push_back(t);
                    if (m_dec < 65535) m_dec++;
                    push_exp(KPush, 0, 0, m_stk.size(), 0, 0, 0);
                    push_exp(KAssign, lit, 1, m_stk.size(), 0, 0, 0);
                    lat = 3;
                end
            end
            default: begin
                going = 1'b1;
                while (going) begin
                    if (m_stk.size() == 0) begin
                        m_sat = 0; m_err = 0;
                        push_exp(KDone, 0, 0, 0, 0, 0, m_dec);
                        lat += 1;
                        fin = 1'b1;
                        going = 1'b0;
                    end else begin
                        t = m_stk.pop_back();
                        if (!t.flipped) begin
                            t.flipped = 1'b1;
                            m_stk.push_back(t);
                            push_exp(KRestore, 0, 0, m_stk.size(), 0, 0, 0);
                            push_exp(KAssign, t.num, 0, m_stk.size(), 0, 0, 0);
                            lat += 3;
                            going = 1'b0;
                        end else begin
                            push_exp(KPop, 0, 0, m_stk.size(), 0, 0, 0);
                            lat += 2;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [1:0] st, input int lit, input bit val, output bit fin);
        int lat;
        bit exp_fin;
        int n;
        model_ack(st, lit, val, lat, exp_fin);
        eval_ack     = 1'b1;
        eval_status  = st;
        eval_lit_num = LW'(lit);
        eval_lit_val = val;
        step();
        eval_ack     = 1'b0;
        eval_status  = 2'($urandom);
        eval_lit_num = LW'($urandom);
        eval_lit_val = 1'($urandom);
        check("req_drop_after_ack", int'(eval_req), 0);
        n = 1;
        while (!eval_req && !done && n < 200) begin
            if (stray_en) begin
                eval_ack     = ($urandom_range(0, 3) == 0);
                eval_status  = 2'($urandom);
                eval_lit_num = LW'($urandom_range(0, NUM_LIT));
                start        = ($urandom_range(0, 7) == 0);
            end
            step();
            n++;
        end
        eval_ack = 1'b0;
        start    = 1'b0;
        check("latency", n, lat);
        check("end_is_done", int'(done), int'(exp_fin));
        fin = done;
    endtask

    task automatic run_solve(input bit rnd);
        int   acks;
        int   d;
        bit   fin;
        rsp_t r;
        acks = 0;
        fin  = 1'b0;
        m_stk.delete();
        m_dec = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("req_rise", int'(eval_req), 1);
        check("sat_clr", int'(sat), 0);
        check("err_clr", int'(err), 0);
        check("dec_clr", int'(dec_count), 0);
        while (!fin && eval_req) begin
            d = int'($urandom_range(0, 3));
            repeat (d) step();
            if (script.size() > 0) r = script.pop_front();
            else if (rnd && acks < 40) r = rand_rsp();
            else begin
                r.st = 2'b10; r.lit = 0; r.val = 1'b0;
            end
            respond(r.st, r.lit, r.val, fin);
            acks++;
        end
        if (!fin) return;
        step();
        check("done_single", int'(done), 0);
        check("sat_hold", int'(sat), m_sat);
        check("err_hold", int'(err), m_err);
        check("req_idle", int'(eval_req), 0);
    endtask

    function automatic int all_outs();
        return int'({eval_req, snap_push, snap_restore, snap_pop, assign_valid, assign_num,
                     assign_val, depth, done, sat, err, dec_count});
    endfunction

    // Monitor: every command pulse or done pops one expected event.
    always @(negedge clk) begin
        int   npulse;
        int   kind;
        exp_t e;
        if (rst_n) begin
            npulse = int'(snap_push) + int'(snap_restore) + int'(snap_pop)
                   + int'(assign_valid) + int'(done);
            if (!assign_valid) check("assign_idle_zero", int'({assign_num, assign_val}), 0);
            if (npulse != 0) begin
                check("pulse_onehot", npulse, 1);
                kind = snap_push ? KPush : snap_restore ? KRestore : snap_pop ? KPop
                     : assign_valid ? KAssign : KDone;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected none (t=%0t)",
                             kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("depth", int'(depth), e.dep);
                    if (e.kind == KAssign) begin
                        check("assign_num", int'(assign_num), e.num);
                        check("assign_val", int'(assign_val), e.val);
                    end
                    if (e.kind == KDone) begin
                        check("done_sat", int'(sat), e.sat);
                        check("done_err", int'(err), e.err);
                        check("done_dec_count", int'(dec_count), e.dec);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit fin;
        int lat;
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        add(2'b10, 0, 0);                       // immediate SAT
        run_solve(1'b0);
        add(2'b00, 3, 0); add(2'b10, 0, 0);     // single decision
        run_solve(1'b0);
        add(2'b11, 2, 0); add(2'b01, 0, 0);     // unit then root conflict
        run_solve(1'b0);
        add(2'b00, 2, 0); add(2'b01, 0, 0); add(2'b01, 0, 0);   // full backtrack
        run_solve(1'b0);
        add(2'b00, 0, 0);                       // branch literal 0
        run_solve(1'b0);
        for (int i = 1; i <= SD; i++) add(2'b00, i, 0);
        add(2'b00, 3, 0);                       // stack overflow
        run_solve(1'b0);
        add(2'b00, 1, 0); add(2'b00, 2, 0); add(2'b00, 3, 0);
        repeat (4) add(2'b01, 0, 0);            // multi-level backtrack to root
        run_solve(1'b0);

        stray_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat (int'($urandom_range(0, 3))) step();
            check("idle_sat_hold", int'(sat), m_sat);
            run_solve(1'b1);
        end
        stray_en = 1'b0;

        // Reset while a second-level PUSH is on the outputs.
        m_stk.delete();
        m_dec = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        respond(2'b00, 1, 0, fin);
        model_ack(2'b00, 4, 0, lat, fin);
        eval_ack     = 1'b1;
        eval_status  = 2'b00;
        eval_lit_num = LW'(4);
        step();
        eval_ack = 1'b0;
        check("push_before_rst", int'(snap_push), 1);
        check("depth_before_rst", int'(depth), 2);
        #1 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("post_reset_req", int'(eval_req), 0);
        check("post_reset_depth", int'(depth), 0);
        add(2'b00, 5, 1); add(2'b10, 0, 0);
        run_solve(1'b0);

        repeat (2) step();
        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
